// File: rtl/uart_tx_arbiter_if.sv
// Requester-side valid/ready words and transmitter-side launch signals
// shared between the word sources, the arbiter and the UART transmitter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
) ();
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          tx_start_o;
    logic [DATA_WIDTH-1:0]         tx_data_o;
    logic                          tx_busy_i;
    logic [NUM_REQ-1:0]            grant_o;
    logic [ID_W-1:0]               grant_id_o;

    // Arbiter side
    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  req_last_i,
        input  tx_busy_i,
        output req_ready_o,
        output tx_start_o,
        output tx_data_o,
        output grant_o,
        output grant_id_o
    );

    // Word sources and transmitter side
    modport master (
        output req_valid_i,
        output req_data_i,
        output req_last_i,
        output tx_busy_i,
        input  req_ready_o,
        input  tx_start_o,
        input  tx_data_o,
        input  grant_o,
        input  grant_id_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ word sources;
// a grant is held until end-of-packet, a burst limit, or an idle timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned ID_W    = $clog2(NUM_REQ);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam int unsigned IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_e;

    state_e                 state_q;
    state_e                 state_d;

    logic [NUM_REQ-1:0]     grant_q;
    logic [ID_W-1:0]        owner_q;
    logic [ID_W-1:0]        ptr_q;
    logic [DATA_WIDTH-1:0]  tx_data_q;
    logic                   last_q;
    logic [BURST_W-1:0]     burst_q;
    logic [IDLE_W-1:0]      idle_q;

    logic [DATA_WIDTH-1:0]  words [NUM_REQ];
    logic [ID_W-1:0]        sel_id;
    logic [ID_W-1:0]        ptr_nxt;
    int                     cand;
    logic                   any_valid;
    logic                   owner_valid;
    logic                   idle_expire;
    logic                   burst_full;

    logic                   ready_en_c;
    logic                   tx_start_c;
    logic                   grant_load;
    logic                   word_take;
    logic                   idle_tick;
    logic                   idle_clear;
    logic                   release_c;

    // Unpack the flat data bus into one word per requester
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            words[i] = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First valid requester at or after the priority pointer, wrapping
    always_comb begin
        sel_id = '0;
        cand   = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            if (bus.req_valid_i[cand]) begin
                sel_id = ID_W'(cand);
            end
        end
    end

    assign any_valid   = |bus.req_valid_i;
    assign owner_valid = bus.req_valid_i[owner_q];
    assign idle_expire = (idle_q == IDLE_W'(IDLE_TIMEOUT - 1));
    assign burst_full  = (burst_q == BURST_W'(MAX_BURST));
    assign ptr_nxt     = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a handshake takes precedence over the idle timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) state_d = S_GRANT;
            end
            S_GRANT: begin
                if (owner_valid)      state_d = S_LAUNCH;
                else if (idle_expire) state_d = S_IDLE;
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy_i) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy_i) begin
                    state_d = (last_q || burst_full) ? S_IDLE : S_GRANT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode and datapath strobes
    always_comb begin
        ready_en_c = 1'b0;
        tx_start_c = 1'b0;
        grant_load = 1'b0;
        word_take  = 1'b0;
        idle_tick  = 1'b0;
        idle_clear = 1'b0;
        release_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                grant_load = any_valid;
            end
            S_GRANT: begin
                ready_en_c = 1'b1;
                if (owner_valid)      word_take = 1'b1;
                else if (idle_expire) release_c = 1'b1;
                else                  idle_tick = 1'b1;
            end
            S_LAUNCH: begin
                tx_start_c = 1'b1;
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy_i) begin
                    if (last_q || burst_full) release_c  = 1'b1;
                    else                      idle_clear = 1'b1;
                end
            end
            default: begin
                ready_en_c = 1'b0;
            end
        endcase
    end

    // Grant, word capture and counters; release clears everything but ptr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
            burst_q   <= '0;
            idle_q    <= '0;
        end else begin
            if (grant_load) begin
                grant_q <= NUM_REQ'(1) << sel_id;
                owner_q <= sel_id;
                burst_q <= '0;
                idle_q  <= '0;
            end
            if (word_take) begin
                tx_data_q <= words[owner_q];
                last_q    <= bus.req_last_i[owner_q];
                burst_q   <= burst_q + BURST_W'(1);
                idle_q    <= '0;
            end
            if (idle_tick) begin
                idle_q <= idle_q + IDLE_W'(1);
            end
            if (idle_clear) begin
                idle_q <= '0;
            end
            if (release_c) begin
                ptr_q   <= ptr_nxt;
                grant_q <= '0;
                owner_q <= '0;
                last_q  <= 1'b0;
                burst_q <= '0;
                idle_q  <= '0;
            end
        end
    end

    assign bus.req_ready_o = ready_en_c ? grant_q : '0;
    assign bus.tx_start_o  = tx_start_c;
    assign bus.tx_data_o   = tx_data_q;
    assign bus.grant_o     = grant_q;
    assign bus.grant_id_o  = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued word sources, a transmitter busy model and
// a packet-level round-robin model predicting the launch order.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int DW           = 8;
    localparam int MAX_BURST    = 4;
    localparam int IDLE_TIMEOUT = 16;
    localparam int QDEPTH       = 64;

    logic clk = 1'b0;
    logic rst_n;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MAX_BURST),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [8:0]    rq [NUM_REQ][QDEPTH];
    int            rh [NUM_REQ];
    int            rt [NUM_REQ];
    int            exp_q [$];
    int            log_id [$];
    int            log_data [$];
    int            m_ptr;
    int            cyc;
    int            n_launch;
    int            n_checks;
    int            n_fail;
    bit            armed;
    bit            rand_tx;
    int            wcnt;
    int            bleft;
    int            bdelay;
    int            blen;
    int            base;
    int            g_cyc;
    logic [DW-1:0] last_data;
    int            fair_exp  [5] = '{0, 1, 2, 3, 0};
    int            burst_exp [7] = '{'h10, 'h11, 'h12, 'h13, 'h30, 'h14, 'h15};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int r, input bit last, input int data);
        if (rh[r] == rt[r]) begin
            rh[r] = 0;
            rt[r] = 0;
        end
        rq[r][rt[r]] = {last, 8'(data)};
        rt[r]++;
    endtask

    // Packet-level round robin over the loaded queues
    task automatic predict();
        int  h [NUM_REQ];
        int  owner;
        int  n;
        bit  done;
        logic [8:0] w;
        for (int i = 0; i < NUM_REQ; i++) h[i] = rh[i];
        for (int guard = 0; guard < 1000; guard++) begin
            owner = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (owner < 0 && h[(m_ptr + k) % NUM_REQ] < rt[(m_ptr + k) % NUM_REQ])
                    owner = (m_ptr + k) % NUM_REQ;
            end
            if (owner < 0) break;
            n    = 0;
            done = 0;
            while (!done) begin
                if (h[owner] >= rt[owner]) begin
                    done = 1;
                end else begin
                    w = rq[owner][h[owner]];
                    h[owner]++;
                    n++;
                    exp_q.push_back(owner * 256 + int'(w[7:0]));
                    if (w[8] || n == MAX_BURST) done = 1;
                end
            end
            m_ptr = (owner + 1) % NUM_REQ;
        end
    endtask

    task automatic drive();
        logic [NUM_REQ-1:0]    v;
        logic [NUM_REQ-1:0]    l;
        logic [NUM_REQ*DW-1:0] d;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rh[i] != rt[i]) begin
                v[i]           = 1'b1;
                l[i]           = rq[i][rh[i]][8];
                d[i*DW +: DW]  = rq[i][rh[i]][7:0];
            end else begin
                v[i]           = 1'b0;
                l[i]           = 1'($urandom);
                d[i*DW +: DW]  = DW'($urandom);
            end
        end
        bus.req_valid_i = v;
        bus.req_last_i  = l;
        bus.req_data_i  = d;
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] hs;
        bit in_rst;
        int e;
        hs     = bus.req_valid_i & bus.req_ready_o;
        in_rst = (rst_n == 1'b0);
        @(posedge clk);
        #1;
        cyc++;
        if (in_rst) begin
            armed         = 0;
            bus.tx_busy_i = 1'b0;
            last_data     = '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) if (hs[i] === 1'b1) rh[i]++;
        end
        if (armed) begin
            if (wcnt > 0) begin
                wcnt--;
            end else if (bleft > 0) begin
                bus.tx_busy_i = 1'b1;
                bleft--;
            end else begin
                bus.tx_busy_i = 1'b0;
                armed         = 0;
            end
        end
        if (bus.tx_start_o === 1'b1) begin
            n_launch++;
            if (rand_tx) begin
                bdelay = $urandom_range(0, 3);
                blen   = $urandom_range(1, 8);
            end
            armed = 1;
            wcnt  = bdelay;
            bleft = blen;
            log_id.push_back(int'(bus.grant_id_o));
            log_data.push_back(int'(bus.tx_data_o));
            check("start expected", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("launch owner", 32'(bus.grant_id_o), 32'(e / 256));
                check("launch data", 32'(bus.tx_data_o), 32'(e % 256));
                last_data = DW'(e % 256);
            end
        end else begin
            check("data held", 32'(bus.tx_data_o), 32'(last_data));
        end
        check("ready onehot0", 32'($onehot0(bus.req_ready_o)), 32'(1));
        check("ready within grant", 32'(bus.req_ready_o & ~bus.grant_o), 32'(0));
        if (bus.grant_o === '0)
            check("grant_id idle", 32'(bus.grant_id_o), 32'(0));
        else
            check("grant matches id", 32'(bus.grant_o), 32'(4'b0001 << bus.grant_id_o));
        drive();
    endtask

    function automatic bit quiet();
        bit q;
        q = !armed && (bus.tx_busy_i == 1'b0) && (bus.grant_o == '0);
        for (int i = 0; i < NUM_REQ; i++) if (rh[i] != rt[i]) q = 0;
        return q;
    endfunction

    task automatic run_until_idle(input string tag);
        for (int k = 0; k < 4000 && !quiet(); k++) step();
        check({tag, " finished"}, 32'(quiet()), 32'(1));
        check({tag, " drained"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.req_last_i  = '0;
        bus.tx_busy_i   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rh[i] = 0;
            rt[i] = 0;
        end
        m_ptr = 0; cyc = 0; n_launch = 0; n_checks = 0; n_fail = 0;
        armed = 0; rand_tx = 0; wcnt = 0; bleft = 0; bdelay = 0; blen = 20;
        last_data = '0;

        // Reset state
        repeat (3) step();
        check("reset grant", 32'(bus.grant_o), 32'(0));
        check("reset grant_id", 32'(bus.grant_id_o), 32'(0));
        check("reset ready", 32'(bus.req_ready_o), 32'(0));
        check("reset start", 32'(bus.tx_start_o), 32'(0));
        check("reset data", 32'(bus.tx_data_o), 32'(0));
        rst_n = 1'b1;
        step();

        // Single requester, one-word packet, 20-cycle frame
        push_word(2, 1'b1, 'hA5);
        predict();
        drive();
        step();
        check("t1 grant", 32'(bus.grant_o), 32'(4'b0100));
        check("t1 grant_id", 32'(bus.grant_id_o), 32'(2));
        check("t1 ready", 32'(bus.req_ready_o), 32'(4'b0100));
        step();
        check("t1 start", 32'(bus.tx_start_o), 32'(1));
        check("t1 data", 32'(bus.tx_data_o), 32'('hA5));
        run_until_idle("t1");

        // Pointer now sits at 3
        blen = 4;
        push_word(0, 1'b1, 'h01);
        push_word(3, 1'b1, 'h03);
        predict();
        drive();
        step();
        check("ptr after release", 32'(bus.grant_id_o), 32'(3));
        run_until_idle("ptr");

        // Fairness from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_ptr = 0;
        log_id.delete();
        push_word(0, 1'b1, 'h40);
        push_word(0, 1'b1, 'h41);
        push_word(1, 1'b1, 'h50);
        push_word(2, 1'b1, 'h60);
        push_word(3, 1'b1, 'h70);
        predict();
        drive();
        run_until_idle("fair");
        check("fair grants", 32'(log_id.size()), 32'(5));
        for (int k = 0; k < 5; k++)
            check("fair order", (k < log_id.size()) ? 32'(log_id[k]) : 32'hFFFF_FFFF, 32'(fair_exp[k]));

        // Burst limit with a competing requester
        log_data.delete();
        for (int j = 0; j < 6; j++) push_word(1, 1'b0, 'h10 + j);
        push_word(3, 1'b1, 'h30);
        predict();
        drive();
        run_until_idle("burst");
        for (int k = 0; k < 7; k++)
            check("burst word", (k < log_data.size()) ? 32'(log_data[k]) : 32'hFFFF_FFFF, 32'(burst_exp[k]));

        // Idle timeout after a non-last word
        base = n_launch;
        push_word(0, 1'b0, 'h5C);
        predict();
        drive();
        for (int k = 0; k < 200 && n_launch == base; k++) step();
        check("idle launch", 32'(n_launch), 32'(base + 1));
        for (int k = 0; k < 200 && bus.req_ready_o[0] !== 1'b1; k++) step();
        g_cyc = cyc;
        for (int k = 0; k < 200 && bus.grant_o != '0; k++) step();
        check("idle release cycles", 32'(cyc - g_cyc), 32'(IDLE_TIMEOUT));
        check("idle no extra start", 32'(n_launch), 32'(base + 1));
        run_until_idle("idle");

        // Transmitter raises busy three cycles late
        bdelay = 3;
        blen   = 5;
        base   = n_launch;
        push_word(1, 1'b1, 'h77);
        push_word(2, 1'b1, 'h88);
        predict();
        drive();
        for (int k = 0; k < 200 && n_launch == base; k++) step();
        check("late busy launch", 32'(n_launch), 32'(base + 1));
        for (int k = 0; k < 3; k++) begin
            step();
            check("late busy ready", 32'(bus.req_ready_o), 32'(0));
            check("late busy start", 32'(bus.tx_start_o), 32'(0));
            check("late busy grant", 32'(bus.grant_o), 32'(4'b0010));
        end
        run_until_idle("late busy");
        bdelay = 0;

        // Reset while waiting for the frame to complete
        blen = 10;
        base = n_launch;
        push_word(2, 1'b1, 'h5A);
        predict();
        drive();
        for (int k = 0; k < 200 && n_launch == base; k++) step();
        check("midrst launch", 32'(n_launch), 32'(base + 1));
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("midrst grant", 32'(bus.grant_o), 32'(0));
        check("midrst grant_id", 32'(bus.grant_id_o), 32'(0));
        check("midrst ready", 32'(bus.req_ready_o), 32'(0));
        check("midrst start", 32'(bus.tx_start_o), 32'(0));
        check("midrst data", 32'(bus.tx_data_o), 32'(0));
        rst_n = 1'b1;
        m_ptr = 0;
        blen  = 3;
        push_word(1, 1'b1, 'h21);
        push_word(3, 1'b1, 'h23);
        predict();
        drive();
        step();
        check("midrst regrant", 32'(bus.grant_o), 32'(4'b0010));
        run_until_idle("midrst");

        // Random packets with random transmitter timing
        rand_tx = 1;
        for (int r = 0; r < 10; r++) begin
            int tot;
            int n;
            tot = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                n = $urandom_range(0, 5);
                for (int j = 0; j < n; j++)
                    push_word(i, $urandom_range(0, 2) == 0, $urandom_range(0, 255));
                tot += n;
            end
            if (tot == 0) push_word(0, 1'b1, 'h99);
            predict();
            drive();
            run_until_idle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
